instruction_prefetch: RTL and testbench

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

---
 rtl/instruction_prefetch_pkg.sv | 19 +
 rtl/instruction_prefetch_fetch_queue.sv | 63 ++++++
 rtl/instruction_prefetch.sv | 138 +++++++++++++
 tb/tb_instruction_prefetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instruction_prefetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // no request outstanding
    ST_WAIT  = 2'd1,  // one request accepted, awaiting its response
    ST_DROP  = 2'd2   // outstanding response must be discarded
  } fetch_state_t;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned PC_INC     = 4;

  // Common 64-bit adder used for PC arithmetic.
  function automatic logic [63:0] add64(input logic [63:0] a, input logic [63:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/instruction_prefetch_fetch_queue.sv
// Small FIFO holding fetched {instruction, pc} entries; head is zeroed when empty.
module fetch_queue #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head entry, forced to zero while the queue is empty.
  always_comb begin
    head_data = '0;
    if (!empty) head_data = mem[rd_ptr];
  end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: single-outstanding fetch sequencer feeding a decode queue.
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INST_W   = INST_WIDTH,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_link
);

  localparam int unsigned ENTRY_W = INST_W + ADDR_W;
  localparam int unsigned CNT_W   = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending_load;
  logic              req_valid;
  logic              q_push;
  logic              q_pop;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENTRY_W-1:0] q_head;

  assign pc_inc = ADDR_W'(add64(64'(pc), 64'(PC_INC)));

  // Fetch sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  // PC register, loaded on accepted request or redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        pc <= RESET_PC;
    else if (pc_load) pc <= pc_next;
  end

  // Address of the single outstanding request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             pending_pc <= '0;
    else if (pending_load) pending_pc <= pc;
  end

  // Next-state, request and queue control; redirect overrides everything.
  always_comb begin
    state_next   = state;
    req_valid    = 1'b0;
    q_push       = 1'b0;
    q_flush      = 1'b0;
    pc_load      = 1'b0;
    pc_next      = pc;
    pending_load = 1'b0;
    if (redirect_valid) begin
      q_flush = 1'b1;
      pc_load = 1'b1;
      pc_next = redirect_target & ~ADDR_W'(3);
      case (state)
        ST_WAIT, ST_DROP: state_next = imem_resp_valid ? ST_FETCH : ST_DROP;
        default:          state_next = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          req_valid = fetch_en && !q_full;
          if (req_valid && imem_req_ready) begin
            pending_load = 1'b1;
            pc_load      = 1'b1;
            pc_next      = pc_inc;
            state_next   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            q_push     = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

  assign imem_req_valid = req_valid && !reset;
  assign imem_req_addr  = pc;
  assign q_pop          = inst_valid && inst_ready;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data ({imem_resp_data, pending_pc}),
    .pop       (q_pop),
    .flush     (q_flush),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst_out   = q_head[ENTRY_W-1:ADDR_W];
  assign inst_pc    = q_head[ADDR_W-1:0];
  assign inst_link  = ADDR_W'(add64(64'(inst_pc), 64'(PC_INC)));

  // A response must never arrive for a push into a full queue.
  a_no_push_full: assert property (@(posedge clock) disable iff (reset)
    !(state == ST_WAIT && imem_resp_valid && !redirect_valid && q_full));

endmodule

// File: tb/tb_instruction_prefetch.sv
// Scoreboard bench for instruction_prefetch with a small latency-configurable memory model.
module tb_instruction_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic [63:0] inst_link;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic [63:0] link;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  instruction_prefetch #(
    .ADDR_W   (64),
    .INST_W   (32),
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_link       (inst_link)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_inst(input logic [63:0] pc, input logic [31:0] data, input logic [63:0] link);
    exp_t e;
    e.pc = pc;
    e.data = data;
    e.link = link;
    sbq.push_back(e);
  endtask

  // Memory model: data = {8'hA5, addr[23:0]}, response mem_gap cycles after the one following accept.
  int unsigned mem_gap = 0;
  int unsigned mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic        mem_fire = 1'b0;
  logic [63:0] mem_addr_s = '0;
  logic [63:0] mem_addr = '0;

  always begin
    @(negedge clock);
    mem_fire   = imem_req_valid && imem_req_ready;
    mem_addr_s = imem_req_addr;
    @(posedge clock);
    #1;
    imem_resp_valid = 1'b0;
    if (reset) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_fire) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_gap;
        mem_addr = mem_addr_s;
      end
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = {8'hA5, mem_addr[23:0]};
          mem_pend        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // Monitor: every consumed head entry must match the next expected entry.
  always @(negedge clock) begin
    if (!reset && inst_valid && inst_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst actual_pc=%h required=none", inst_pc);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_inst_pc", inst_pc, mon_e.pc);
        chk("sb_inst_out", 64'(inst_out), 64'(mon_e.data));
        chk("sb_inst_link", inst_link, mon_e.link);
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_inst_link", inst_link, 64'h4);
    chk("rst_inst_out", 64'(inst_out), 64'h0);

    // Streaming from reset with 1-cycle memory
    expect_inst(64'h0, 32'hA500_0000, 64'h4);
    expect_inst(64'h4, 32'hA500_0004, 64'h8);
    expect_inst(64'h8, 32'hA500_0008, 64'hC);
    reset = 1'b0;
    tick();
    chk("lat_e1_inst_valid", 64'(inst_valid), 64'd0);
    tick();
    chk("lat_e2_inst_valid", 64'(inst_valid), 64'd1);
    chk("lat_e2_inst_pc", inst_pc, 64'h0);
    tick(3);
    fetch_en = 1'b0;
    tick(4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_req_addr", imem_req_addr, 64'hC);

    // Fill queue with decode stalled
    redirect_valid  = 1'b1;
    redirect_target = 64'h0;
    fetch_en        = 1'b1;
    inst_ready      = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick(10);
    chk("full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("full_req_addr", imem_req_addr, 64'h10);
    chk("full_inst_valid", 64'(inst_valid), 64'd1);
    chk("full_inst_pc", inst_pc, 64'h0);
    chk("full_inst_out", 64'(inst_out), 64'hA500_0000);
    expect_inst(64'h0, 32'hA500_0000, 64'h4);
    expect_inst(64'h4, 32'hA500_0004, 64'h8);
    expect_inst(64'h8, 32'hA500_0008, 64'hC);
    expect_inst(64'hC, 32'hA500_000C, 64'h10);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("after_pop_req_valid", 64'(imem_req_valid), 64'd1);
    chk("after_pop_req_addr", imem_req_addr, 64'h10);
    expect_inst(64'h10, 32'hA500_0010, 64'h14);
    tick();
    fetch_en = 1'b0;
    #1;
    chk("after_pop_wait_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    inst_ready = 1'b1;
    tick(8);

    // Redirect while waiting, response two cycles later
    mem_gap = 1;
    expect_inst(64'h1000, 32'hA500_1000, 64'h1004);
    fetch_en = 1'b1;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 64'h1002;
    #1;
    chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drop_req_valid", 64'(imem_req_valid), 64'd0);
    chk("drop_req_addr", imem_req_addr, 64'h1000);
    chk("drop_inst_valid", 64'(inst_valid), 64'd0);
    tick();
    chk("post_drop_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_drop_req_addr", imem_req_addr, 64'h1000);
    chk("post_drop_inst_valid", 64'(inst_valid), 64'd0);
    tick();
    fetch_en = 1'b0;
    tick(6);
    mem_gap = 0;
    tick();

    // Redirect coinciding with the response
    expect_inst(64'h2000, 32'hA500_2000, 64'h2004);
    fetch_en = 1'b1;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("same_cyc_req_valid", 64'(imem_req_valid), 64'd1);
    chk("same_cyc_req_addr", imem_req_addr, 64'h2000);
    chk("same_cyc_inst_valid", 64'(inst_valid), 64'd0);
    tick();
    fetch_en = 1'b0;
    tick(4);

    // PC wrap at the top of the address space, then a 3-cycle fetch stall
    expect_inst(64'hFFFF_FFFF_FFFF_FFFC, 32'hA5FF_FFFC, 64'h0);
    expect_inst(64'h0, 32'hA500_0000, 64'h4);
    redirect_valid  = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    #1;
    chk("top_req_valid", 64'(imem_req_valid), 64'd1);
    chk("top_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    fetch_en = 1'b0;
    #1;
    chk("wrap_req_addr", imem_req_addr, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fe_low_req_valid", 64'(imem_req_valid), 64'd0);
      chk("fe_low_req_addr", imem_req_addr, 64'h0);
    end
    fetch_en = 1'b1;
    #1;
    chk("fe_high_req_valid", 64'(imem_req_valid), 64'd1);
    chk("fe_high_req_addr", imem_req_addr, 64'h0);
    tick();
    fetch_en = 1'b0;
    tick(4);

    // Reset while waiting with three entries queued
    inst_ready = 1'b0;
    fetch_en   = 1'b1;
    tick(6);
    chk("pre_rst_inst_valid", 64'(inst_valid), 64'd1);
    chk("pre_rst_inst_pc", inst_pc, 64'h4);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mid_rst_req_addr", imem_req_addr, 64'h0);
    chk("mid_rst_inst_out", 64'(inst_out), 64'h0);
    fetch_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("post_rst_req_addr", imem_req_addr, 64'h0);
    chk("post_rst_inst_pc", inst_pc, 64'h0);
    chk("post_rst_inst_link", inst_link, 64'h4);

    tick(2);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
